// File: rtl/chacha_ks_xor_engine.sv
// ChaCha20 keystream prefetch buffer and payload XOR stage on valid/ready streams.
// Optional Poly1305 length-block output is built when CHACHA_LEN_BLOCK_EN is defined.
module chacha_ks_xor_engine #(
  parameter int DATA_W   = 128,
  parameter int KS_DEPTH = 2,
  parameter int CNT_W    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ks_req,
  input  logic                ks_valid,
  input  logic [511:0]        ks_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic [CNT_W-1:0]    pld_bytes,
  output logic                busy,
  output logic                done
`ifdef CHACHA_LEN_BLOCK_EN
  ,
  input  logic [CNT_W-1:0]    aad_bytes,
  output logic                len_valid,
  input  logic                len_ready,
  output logic [127:0]        len_block
`endif
);

  localparam int KB     = DATA_W / 8;
  localparam int LANES  = 512 / DATA_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int OCC_W  = $clog2(KS_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [511:0]      r_buf [KS_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
  logic [OCC_W-1:0]  r_occ;
  logic [LANE_W-1:0] r_lane;
  logic              r_outstanding, r_ks_req, r_out_valid, r_out_last, r_done;
  logic [DATA_W-1:0] r_out_data, w_lane_ks, w_out_data_nxt;
  logic [KB-1:0]     r_out_keep;
  logic [CNT_W-1:0]  r_pld;
  logic              w_in_ready, w_acc, w_acc_last, w_lane_last, w_pop, w_push;
  logic              w_req_fire, w_last_out, w_done;

  function automatic logic [CNT_W-1:0] popcount(input logic [KB-1:0] keep);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KB; i++) n = n + CNT_W'(keep[i]);
    return n;
  endfunction

  assign w_wr_ptr_inc = (KS_DEPTH == 1) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (KS_DEPTH == 1) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_lane_ks    = r_buf[r_rd_ptr][r_lane * DATA_W +: DATA_W];
  assign w_lane_last  = (r_lane == LANE_W'(LANES - 1));
  assign w_in_ready   = (r_state == S_RUN) && (r_occ != '0) && (!r_out_valid || out_ready);
  assign w_acc        = in_valid && w_in_ready;
  assign w_acc_last   = w_acc && in_last;
  assign w_pop        = w_acc && !in_last && w_lane_last;
  // A stale block (nothing outstanding) is dropped here; so is one racing the final beat.
  assign w_push       = ks_valid && r_outstanding && !w_acc_last;
  assign w_req_fire   = (r_state == S_RUN) && !r_outstanding && (r_occ < OCC_W'(KS_DEPTH))
                        && !w_acc_last && !start;
  assign w_last_out   = r_out_valid && out_ready && r_out_last;
  assign w_done       = w_last_out && (r_state == S_DRAIN) && !start;

  always_comb begin
    w_out_data_nxt = '0;
    for (int i = 0; i < KB; i++) begin
      if (in_keep[i]) w_out_data_nxt[8*i +: 8] = in_data[8*i +: 8] ^ w_lane_ks[8*i +: 8];
      else            w_out_data_nxt[8*i +: 8] = 8'h00;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_RUN:   w_state_nxt = w_acc_last ? S_DRAIN : S_RUN;
        S_DRAIN: w_state_nxt = w_last_out ? S_IDLE : S_DRAIN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push && !start && !rst) r_buf[r_wr_ptr] <= ks_data;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_occ         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_lane        <= '0;
      r_outstanding <= 1'b0;
      r_ks_req      <= 1'b0;
      r_pld         <= '0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
      if (rst) begin
        r_out_data <= '0;
        r_out_keep <= '0;
        r_out_last <= 1'b0;
      end
    end else begin
      r_ks_req <= w_req_fire;
      r_done   <= w_done;
      if (w_acc_last) begin
        // Message complete: whatever keystream remains is discarded.
        r_occ         <= '0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_lane        <= '0;
        r_outstanding <= 1'b0;
      end else begin
        if (w_req_fire)  r_outstanding <= 1'b1;
        else if (w_push) r_outstanding <= 1'b0;
        if (w_push) r_wr_ptr <= w_wr_ptr_inc;
        if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
        r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        if (w_acc) r_lane <= w_lane_last ? '0 : r_lane + LANE_W'(1);
      end
      if (w_acc) begin
        r_pld       <= r_pld + popcount(in_keep);
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_data_nxt;
        r_out_keep  <= in_keep;
        r_out_last  <= in_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef CHACHA_LEN_BLOCK_EN
  logic         r_len_valid;
  logic [127:0] r_len_block;

  // Length block {ct_len, aad_len} is captured with done and held until taken.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_len_valid <= 1'b0;
      r_len_block <= '0;
    end else if (w_done) begin
      r_len_valid <= 1'b1;
      r_len_block <= {64'(r_pld), 64'(aad_bytes)};
    end else if (r_len_valid && len_ready) begin
      r_len_valid <= 1'b0;
    end
  end

  assign len_valid = r_len_valid;
  assign len_block = r_len_block;
`endif

  assign ks_req    = r_ks_req;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign pld_bytes = r_pld;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_chacha_ks_xor_engine.sv
// Bench for chacha_ks_xor_engine: core responder, keystream byte-stream model and output scoreboard.
module tb_chacha_ks_xor_engine;
  localparam int DW = 128, KB = 16, LANES = 4, DEPTH = 2, CW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ks_req, ks_valid = 1'b0;
  logic [511:0] ks_data = '0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [KB-1:0] in_keep = '0, out_keep;
  logic out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [CW-1:0] pld_bytes;
`ifdef CHACHA_LEN_BLOCK_EN
  logic [CW-1:0] aad_bytes = '0;
  logic len_valid, len_ready = 1'b0;
  logic [127:0] len_block;
`endif

  chacha_ks_xor_engine #(.DATA_W(DW), .KS_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .pld_bytes(pld_bytes), .busy(busy), .done(done)
`ifdef CHACHA_LEN_BLOCK_EN
    , .aad_bytes(aad_bytes), .len_valid(len_valid), .len_ready(len_ready), .len_block(len_block)
`endif
  );

  typedef struct { logic [DW-1:0] d; logic [KB-1:0] k; logic l; } beat_t;

  int n_chk = 0, n_err = 0;
  int epoch = 0, cyc = 0, req_cnt = 0, done_cnt = 0, req0 = 0, done0 = 0;
  int fixed_lat = 0, ks_pos = 0, stall_len = 0, stall_tok = 0;
  bit ks_pattern = 1'b0, rand_rdy = 1'b0, hold_low = 1'b0;
  logic [7:0] ks_q[$];
  beat_t exp_q[$];
  int due_q[$], ep_q[$];
  logic [CW-1:0] model_bytes = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keystream core model: answers each ks_req in order after a latency; blocks of the
  // current message are appended to the model's keystream byte stream.
  always @(negedge clk) begin
    logic [511:0] blk;
    cyc++;
    if (ks_req) begin
      req_cnt++;
      due_q.push_back(cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4))));
      ep_q.push_back(epoch);
    end
    ks_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom;
      if (ks_pattern) for (int b = 0; b < 64; b++) blk[8*b +: 8] = 8'(b);
      ks_valid = 1'b1;
      ks_data  = blk;
      if (ep_q[0] == epoch) for (int b = 0; b < 64; b++) ks_q.push_back(blk[8*b +: 8]);
      void'(due_q.pop_front());
      void'(ep_q.pop_front());
    end
  end

  // Downstream sink: random or forced backpressure.
  always @(posedge clk) begin
    int seen_tok, s_cnt;
    #1;
    if (stall_tok != seen_tok) begin seen_tok = stall_tok; s_cnt = stall_len; end
    if (hold_low || s_cnt > 0) begin
      out_ready = 1'b0;
      if (s_cnt > 0) s_cnt--;
    end else begin
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, hold stability under backpressure, done counting.
  always @(negedge clk) begin
    bit prev_hold;
    logic [DW-1:0] p_data;
    logic [KB-1:0] p_keep;
    logic p_last;
    beat_t e;
    if (done) done_cnt++;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, p_data);
        chk("hold_keep", out_keep, p_keep);
        chk("hold_last", out_last, p_last);
      end
      if (out_valid && !out_ready) chk("in_ready_blocked", in_ready, 1'b0);
      prev_hold = out_valid && !out_ready;
      p_data = out_data; p_keep = out_keep; p_last = out_last;
      if (out_valid && out_ready) begin
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_beat: got %0h expected none", out_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_keep", out_keep, e.k);
          chk("out_last", out_last, e.l);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_msg();
    start = 1'b1;
    epoch++;
    ks_q.delete();
    ks_pos = 0;
    model_bytes = '0;
    req0 = req_cnt;
    done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
    int t;
    bit acc;
    beat_t e;
    t = 0; acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    while (!acc && t < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        n_chk++;
        assert (ks_q.size() >= ks_pos + KB) else begin
          n_err++;
          $error("FAIL ks_available: got %0d expected >= %0d", ks_q.size(), ks_pos + KB);
        end
        for (int i = 0; i < KB; i++)
          e.d[8*i +: 8] = (k[i] && ks_q.size() > ks_pos + i) ? (d[8*i +: 8] ^ ks_q[ks_pos + i]) : 8'h00;
        e.k = k; e.l = l;
        exp_q.push_back(e);
        ks_pos += KB;
        model_bytes += CW'($countones(k));
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_chk++;
    assert (acc) else begin n_err++; $error("FAIL accept_timeout: got %0d expected 1", acc); end
  endtask

  task automatic finish_msg(input int nbeats);
    int t, nblk, nreq;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 400) begin @(negedge clk); t++; end
    n_chk++;
    assert (t < 400) else begin n_err++; $error("FAIL drain_timeout: got %0d expected < 400", t); end
    @(posedge clk); #1;
    idle(2);
    chk("busy_idle", busy, 1'b0);
    chk("pld_bytes", pld_bytes, model_bytes);
    chk("done_once", 32'(done_cnt - done0), 32'd1);
    nblk = (nbeats + LANES - 1) / LANES;
    nreq = req_cnt - req0;
    n_chk++;
    assert (nreq >= nblk && nreq <= nblk + DEPTH) else begin
      n_err++;
      $error("FAIL ks_req_count: got %0d expected %0d..%0d", nreq, nblk, nblk + DEPTH);
    end
    idle(8);
  endtask

  task automatic send_msg(input int nb, input int lastbytes, input bit zero_data, input int stall_at,
                          input bit gaps);
    logic [KB:0] m;
    logic [KB-1:0] k;
    logic [DW-1:0] d;
    start_msg();
    for (int b = 0; b < nb; b++) begin
      d = zero_data ? '0 : {$urandom, $urandom, $urandom, $urandom};
      m = ({{KB{1'b0}}, 1'b1} << lastbytes) - 1'b1;
      k = (b == nb - 1) ? m[KB-1:0] : {KB{1'b1}};
      if (b == stall_at) begin stall_len = 5; stall_tok++; end
      send_beat(d, k, b == nb - 1);
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
    end
    finish_msg(nb);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ks_req", ks_req, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_keep", out_keep, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_pld_bytes", pld_bytes, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
`ifdef CHACHA_LEN_BLOCK_EN
    chk("rst_len_valid", len_valid, 1'b0);
`endif
  endtask

  initial begin
    int t, d0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    idle(2);

    // Counting-byte keystream, zero payload: outputs are the raw keystream lanes.
    ks_pattern = 1'b1;
    send_msg(4, 16, 1'b1, -1, 1'b0);
    ks_pattern = 1'b0;

    // Nine beats ending on a half-keep beat: third block needed, 136 bytes counted.
    send_msg(9, 8, 1'b0, -1, 1'b0);
    chk("pld_136", pld_bytes, 64'd136);

    // Five-cycle downstream stall mid-message.
    send_msg(12, 16, 1'b0, 3, 1'b0);

    // Restart while a request is in flight; its late block must be ignored.
    fixed_lat = 2;
    start_msg();
    t = 0;
    while (!ks_req && t < 20) begin @(negedge clk); t++; end
    n_chk++;
    assert (t < 20) else begin n_err++; $error("FAIL stale_req_wait: got %0d expected < 20", t); end
    @(posedge clk); #1;
    start_msg();
    fixed_lat = 0;
    for (int b = 0; b < 4; b++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, {KB{1'b1}}, b == 3);
    finish_msg(4);

    // Random messages with backpressure and input gaps.
    rand_rdy = 1'b1;
    for (int m = 0; m < 6; m++)
      send_msg(int'($urandom_range(1, 14)), int'($urandom_range(1, 16)), 1'b0, -1, 1'b1);
    rand_rdy = 1'b0;

    // Reset while draining the final beat.
    hold_low = 1'b1;
    idle(2);
    start_msg();
    send_beat({$urandom, $urandom, $urandom, $urandom}, {KB{1'b1}}, 1'b1);
    idle(3);
    chk("drain_busy", busy, 1'b1);
    chk("drain_out_valid", out_valid, 1'b1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    rst = 1'b0;
    exp_q.delete();
    hold_low = 1'b0;
    idle(6);
    chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
    send_msg(5, 3, 1'b0, -1, 1'b0);

`ifdef CHACHA_LEN_BLOCK_EN
    aad_bytes = 64'd12;
    send_msg(8, 2, 1'b0, -1, 1'b0);
    chk("len_valid", len_valid, 1'b1);
    chk("len_block", len_block, {64'd114, 64'd12});
    idle(3);
    chk("len_valid_held", len_valid, 1'b1);
    chk("len_block_held", len_block, {64'd114, 64'd12});
    len_ready = 1'b1;
    idle(1);
    len_ready = 1'b0;
    chk("len_valid_clear", len_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
